alu_iterative: RTL and testbench



---
 rtl/alu_iterative_pkg.sv | 34 +++
 rtl/alu_shift_step.sv | 29 ++
 rtl/alu_iterative.sv | 157 +++++++++++++++
 tb/tb_alu_iterative.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iterative_pkg.sv
// Shared types for the execute-stage ALU: operation codes, flag bundle and control states.
package alu_iterative_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSrl  = 4'd3,
    AluSra  = 4'd4,
    AluSlt  = 4'd5,
    AluSltu = 4'd6,
    AluXor  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
    logic cf;
  } alu_flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_t;

  function automatic logic is_shift(alu_t op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: moves the accumulator by at most SHIFT_STEP bits.
module alu_shift_step
  import alu_iterative_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned AmtW      = $clog2(SHIFT_STEP) + 1
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [AmtW-1:0] amt_i,
  input  alu_t            kind_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] acc_o
);

  logic [XLEN-1:0] fill;

  always_comb begin
    // Ones in the vacated upper bits when an arithmetic shift of a negative source
    fill = sign_i ? ~({XLEN{1'b1}} >> amt_i) : '0;
    case (kind_i)
      AluSll:  acc_o = acc_i << amt_i;
      AluSrl:  acc_o = acc_i >> amt_i;
      AluSra:  acc_o = (acc_i >> amt_i) | fill;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU with registered result/flags; shifts iterate SHIFT_STEP bits per cycle.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_t            aluctr,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags,
  output logic            busy
);

  localparam int unsigned AmtW  = $clog2(SHIFT_STEP) + 1;
  localparam logic [5:0]  StepW = 6'(SHIFT_STEP);

  alu_state_t      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [4:0]      rem_q, rem_d;
  alu_t            kind_q, kind_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] result_q, result_d;
  alu_flags_t      flags_q, flags_d;

  logic [XLEN:0]   sum, diff;
  logic [XLEN-1:0] comb_res, shifted;
  logic            comb_of, comb_cf, comb_def;
  alu_flags_t      comb_flags;
  logic [4:0]      shamt, step, rem_next;
  logic            accept, take_shift;

  assign sum        = {1'b0, op_a} + {1'b0, op_b};
  assign diff       = {1'b0, op_a} - {1'b0, op_b};
  assign shamt      = op_b[4:0];
  assign take_shift = is_shift(aluctr) && (shamt != '0);

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift);
  assign result    = result_q;
  assign flags     = flags_q;

  always_comb begin
    comb_res = '0;
    comb_of  = 1'b0;
    comb_cf  = 1'b0;
    comb_def = 1'b1;
    case (aluctr)
      AluAdd: begin
        comb_res = sum[XLEN-1:0];
        comb_cf  = sum[XLEN];
        comb_of  = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      AluSub: begin
        comb_res = diff[XLEN-1:0];
        comb_cf  = diff[XLEN];
        comb_of  = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      // Reached only with shamt==0; nonzero amounts take the iterative path
      AluSll, AluSrl, AluSra: comb_res = op_a;
      AluSlt:  comb_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu: comb_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      AluXor:  comb_res = op_a ^ op_b;
      AluOr:   comb_res = op_a | op_b;
      AluAnd:  comb_res = op_a & op_b;
      default: comb_def = 1'b0;
    endcase
    comb_flags = comb_def ? '{zf: (comb_res == '0), sf: comb_res[XLEN-1], of: comb_of,
                              cf: comb_cf}
                          : '0;
  end

  assign step     = ({1'b0, rem_q} < StepW) ? rem_q : StepW[4:0];
  assign rem_next = rem_q - step;

  alu_shift_step #(
    .XLEN      (XLEN),
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shift_step (
    .acc_i (acc_q),
    .amt_i (step[AmtW-1:0]),
    .kind_i(kind_q),
    .sign_i(sign_q),
    .acc_o (shifted)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    kind_d   = kind_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle, StDone: begin
        // A DONE result waiting on out_ready holds everything
        if ((state_q == StIdle) || out_ready) begin
          state_d = StIdle;
          if (accept) begin
            if (take_shift) begin
              acc_d   = op_a;
              rem_d   = shamt;
              kind_d  = aluctr;
              sign_d  = op_a[XLEN-1];
              state_d = StShift;
            end else begin
              result_d = comb_res;
              flags_d  = comb_flags;
              state_d  = StDone;
            end
          end
        end
      end
      StShift: begin
        acc_d = shifted;
        rem_d = rem_next;
        if (rem_next == '0) begin
          result_d = shifted;
          flags_d  = '{zf: (shifted == '0), sf: shifted[XLEN-1], of: 1'b0, cf: 1'b0};
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      rem_q    <= '0;
      kind_q   <= AluAdd;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      kind_q   <= kind_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: two instances (SHIFT_STEP 1 and 4) share stimulus and a reference model.
module tb_alu_iterative;
  import alu_iterative_pkg::*;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  alu_t        aluctr;
  logic [31:0] op_a, op_b;
  logic [1:0]  in_ready, out_valid, busy;
  logic [31:0] result [2];
  alu_flags_t  flags  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .aluctr(aluctr),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(result[0]), .flags(flags[0]), .busy(busy[0])
  );

  alu_iterative #(.XLEN(32), .SHIFT_STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .aluctr(aluctr),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(result[1]), .flags(flags[1]), .busy(busy[1])
  );

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Reference: plain arithmetic on wide signed/unsigned integers
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint      sa, sb, s;
    logic [63:0] u;
    logic        of, cf, defined;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = 32'h0; of = 1'b0; cf = 1'b0; defined = 1'b1;
    case (op)
      4'd0: begin
        u = 64'(a) + 64'(b); r = u[31:0]; cf = u[32];
        s = sa + sb; of = (s > MaxS) || (s < MinS);
      end
      4'd1: begin
        r = a - b; cf = (a < b);
        s = sa - sb; of = (s > MaxS) || (s < MinS);
      end
      4'd2: r = a << sh;
      4'd3: r = a >> sh;
      4'd4: r = $signed(a) >>> sh;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a ^ b;
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: defined = 1'b0;
    endcase
    f = defined ? {(r == 32'h0), r[31], of, cf} : 4'h0;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b, input int st);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'd2 || op == 4'd3 || op == 4'd4) && sh != 0) return 1 + (sh + st - 1) / st;
    return 1;
  endfunction

  // Issue one op from idle with out_ready high; check result, flags, latency and busy span.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [3:0]  ef;
    int          lat[2];
    int          bz[2];
    int          el;
    model(op, a, b, er, ef);
    aluctr = alu_t'(op); op_a = a; op_b = b; in_valid = 1'b1;
    checks++;
    if (in_ready !== 2'b11) begin
      errors++;
      $display("FAIL issue_ready op=%0d got in_ready=%b expected 11", op, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; aluctr = alu_t'(4'($urandom));
    lat = '{0, 0}; bz = '{0, 0};
    for (int k = 1; k <= 40 && (lat[0] == 0 || lat[1] == 0); k++) begin
      for (int i = 0; i < 2; i++) begin
        if (lat[i] == 0) begin
          if (busy[i]) bz[i]++;
          if (out_valid[i]) begin
            lat[i] = k;
            checks++;
            if (result[i] !== er || flags[i] !== ef) begin
              errors++;
              $display("FAIL result dut%0d op=%0d a=%h b=%h got %h/%h expected %h/%h",
                       i, op, a, b, result[i], flags[i], er, ef);
            end
          end
        end
      end
      if (lat[0] == 0 || lat[1] == 0) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      el = exp_lat(op, b, step_of(i));
      checks++;
      if (lat[i] != el) begin
        errors++;
        $display("FAIL latency dut%0d op=%0d b=%h got %0d expected %0d", i, op, b, lat[i], el);
      end
      checks++;
      if (bz[i] != el - 1) begin
        errors++;
        $display("FAIL busy_span dut%0d op=%0d got %0d expected %0d", i, op, bz[i], el - 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_reset(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || result[i] !== 32'h0 || flags[i] !== 4'h0 ||
          busy[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s dut%0d got v=%b r=%h f=%h busy=%b rdy=%b expected 0/0/0/0/1",
                 name, i, out_valid[i], result[i], flags[i], busy[i], in_ready[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluctr = AluAdd; op_a = 32'h0; op_b = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_reset("reset_state");
  endtask

  task automatic test_directed();
    do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    do_op(4'd1, 32'd3, 32'd5);
    do_op(4'd1, 32'd5, 32'd5);
    do_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op(4'd4, 32'h8000_0000, 32'd31);
    do_op(4'd2, 32'h0000_00F1, 32'hFFFF_FFE3);
    do_op(4'd3, 32'h8765_4321, 32'h0000_0020);
    do_op(4'd5, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op(4'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op(4'd12, 32'h1234_5678, 32'h0000_0000);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      do_op(op, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[10];
    logic [31:0] b[10];
    logic [31:0] er;
    logic [3:0]  ef;
    for (int j = 0; j < 10; j++) begin
      a[j] = $urandom; b[j] = $urandom;
    end
    out_ready = 1'b1;
    aluctr = AluXor; op_a = a[0]; op_b = b[0]; in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (in_ready !== 2'b11) begin
        errors++;
        $display("FAIL b2b_ready op%0d got %b expected 11", j, in_ready);
      end
      @(posedge clk); #1;
      model(4'd7, a[j], b[j], er, ef);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_valid[i] !== 1'b1 || result[i] !== er || flags[i] !== ef) begin
          errors++;
          $display("FAIL b2b_result dut%0d op%0d got v=%b %h/%h expected 1 %h/%h",
                   i, j, out_valid[i], result[i], flags[i], er, ef);
        end
      end
      if (j < 9) begin
        op_a = a[j+1]; op_b = b[j+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2, er1, er2;
    logic [3:0]  ef1, ef2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    model(4'd9, a1, b1, er1, ef1);
    model(4'd0, a2, b2, er2, ef2);
    out_ready = 1'b0;
    aluctr = AluAnd; op_a = a1; op_b = b1; in_valid = 1'b1;
    @(posedge clk); #1;
    aluctr = AluAdd; op_a = a2; op_b = b2;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 || result[i] !== er1 ||
            flags[i] !== ef1) begin
          errors++;
          $display("FAIL stall dut%0d cyc%0d got v=%b rdy=%b %h/%h expected 1 0 %h/%h",
                   i, c, out_valid[i], in_ready[i], result[i], flags[i], er1, ef1);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 2'b11) begin
      errors++;
      $display("FAIL release_ready got %b expected 11", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid[i] !== 1'b1 || result[i] !== er2 || flags[i] !== ef2) begin
        errors++;
        $display("FAIL pending_op dut%0d got v=%b %h/%h expected 1 %h/%h",
                 i, out_valid[i], result[i], flags[i], er2, ef2);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 2'b00) begin
      errors++;
      $display("FAIL drain_idle got out_valid=%b expected 00", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    out_ready = 1'b1;
    aluctr = AluSll; op_a = $urandom | 32'h1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 2'b11) begin
      errors++;
      $display("FAIL mid_shift_busy got %b expected 11", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("reset_mid_shift");
    do_op(4'd0, 32'd2, 32'd2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
